// File: rtl/grf_dual_write.sv
// Dual-write general register file for the pipelined MIPS core: multi-port reads with optional
// same-cycle forwarding, a per-register busy scoreboard, and a registered per-port write trace.
module grf_dual_write #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_READ = 2,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         we0,
    input  logic [ADDR_W-1:0]            wa0,
    input  logic [DATA_W-1:0]            wd0,
    input  logic [31:0]                  wpc0,
    input  logic                         we1,
    input  logic [ADDR_W-1:0]            wa1,
    input  logic [DATA_W-1:0]            wd1,
    input  logic [31:0]                  wpc1,
    input  logic [NUM_READ*ADDR_W-1:0]   ra,
    output logic [NUM_READ*DATA_W-1:0]   rd,
    input  logic                         set_en,
    input  logic [ADDR_W-1:0]            set_addr,
    output logic [(1<<ADDR_W)-1:0]       busy,
    output logic [1:0]                   trc_valid,
    output logic [31:0]                  trc_pc0,
    output logic [31:0]                  trc_pc1,
    output logic [ADDR_W-1:0]            trc_addr0,
    output logic [ADDR_W-1:0]            trc_addr1,
    output logic [DATA_W-1:0]            trc_data0,
    output logic [DATA_W-1:0]            trc_data1
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [1:0]        trc_valid_q;
    logic [31:0]       trc_pc0_q, trc_pc1_q;
    logic [ADDR_W-1:0] trc_addr0_q, trc_addr1_q;
    logic [DATA_W-1:0] trc_data0_q, trc_data1_q;
    logic              eff0, eff1;

    // Port 1 carries the younger writeback, so it shadows port 0 on an address collision.
    assign eff1 = we1 && (wa1 != '0);
    assign eff0 = we0 && (wa0 != '0) && !(we1 && (wa0 == wa1));

    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (eff0) regs_q[wa0] <= wd0;
            if (eff1) regs_q[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            val = regs_q[addr];
            if (addr == '0) begin
                val = '0;
            end else if (BYPASS) begin
                if (eff1 && (wa1 == addr)) begin
                    val = wd1;
                end else if (eff0 && (wa0 == addr)) begin
                    val = wd0;
                end
            end
        end

        assign rd[k*DATA_W +: DATA_W] = val;
    end

    // A fresh issue wins over a retiring write: the new producer is the one still pending.
    always_comb begin
        busy_d = '0;
        for (int n = 1; n < DEPTH; n++) begin
            busy_d[n] = busy_q[n];
            if (set_en && (set_addr == ADDR_W'(n))) begin
                busy_d[n] = 1'b1;
            end else if ((eff0 && (wa0 == ADDR_W'(n))) || (eff1 && (wa1 == ADDR_W'(n)))) begin
                busy_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            busy_q      <= '0;
            trc_valid_q <= 2'b00;
            trc_pc0_q   <= '0;
            trc_pc1_q   <= '0;
            trc_addr0_q <= '0;
            trc_addr1_q <= '0;
            trc_data0_q <= '0;
            trc_data1_q <= '0;
        end else begin
            busy_q      <= busy_d;
            trc_valid_q <= {eff1, eff0};
            if (eff0) begin
                trc_pc0_q   <= wpc0;
                trc_addr0_q <= wa0;
                trc_data0_q <= wd0;
            end
            if (eff1) begin
                trc_pc1_q   <= wpc1;
                trc_addr1_q <= wa1;
                trc_data1_q <= wd1;
            end
        end
    end

    assign busy      = busy_q;
    assign trc_valid = trc_valid_q;
    assign trc_pc0   = trc_pc0_q;
    assign trc_pc1   = trc_pc1_q;
    assign trc_addr0 = trc_addr0_q;
    assign trc_addr1 = trc_addr1_q;
    assign trc_data0 = trc_data0_q;
    assign trc_data1 = trc_data1_q;

endmodule

// File: tb/tb_grf_dual_write.sv
// Directed bench for grf_dual_write with default parameters (32x32, two read ports, bypass on).
module tb_grf_dual_write;

    logic        clk = 1'b0;
    logic        RESET;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1, wpc0, wpc1;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        set_en;
    logic [4:0]  set_addr;
    logic [31:0] busy;
    logic [1:0]  trc_valid;
    logic [31:0] trc_pc0, trc_pc1;
    logic [4:0]  trc_addr0, trc_addr1;
    logic [31:0] trc_data0, trc_data1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grf_dual_write #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_READ (2),
        .BYPASS   (1'b1)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .wpc0      (wpc0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .wpc1      (wpc1),
        .ra        (ra),
        .rd        (rd),
        .set_en    (set_en),
        .set_addr  (set_addr),
        .busy      (busy),
        .trc_valid (trc_valid),
        .trc_pc0   (trc_pc0),
        .trc_pc1   (trc_pc1),
        .trc_addr0 (trc_addr0),
        .trc_addr1 (trc_addr1),
        .trc_data0 (trc_data0),
        .trc_data1 (trc_data1)
    );

    task automatic idle();
        RESET = 1'b0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0;
        wd0 = '0; wd1 = '0; wpc0 = '0; wpc1 = '0; set_en = 1'b0; set_addr = '0;
    endtask

    // Inputs change at the falling edge; the active edge follows half a period later.
    task automatic edge_then_idle();
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        RESET = 1'b1;
        ra = '0;
        edge_then_idle();
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            n_cmp++;
            if (rd !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_rd addr=%0d: got %h want 0", a, rd);
            end
        end
        n_cmp++;
        if (busy !== 32'h0) begin
            n_bad++; $display("FAIL reset_busy: got %h want 0", busy);
        end
        n_cmp++;
        if (trc_valid !== 2'b00) begin
            n_bad++; $display("FAIL reset_trc_valid: got %b want 00", trc_valid);
        end
        n_cmp++;
        if ({trc_pc0, trc_pc1, trc_addr0, trc_addr1, trc_data0, trc_data1} !== '0) begin
            n_bad++;
            $display("FAIL reset_trc_fields: got pc0=%h pc1=%h a0=%h a1=%h d0=%h d1=%h want 0",
                     trc_pc0, trc_pc1, trc_addr0, trc_addr1, trc_data0, trc_data1);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234; wpc0 = 32'h3000;
        ra = {5'd0, 5'd5};
        #1;
        n_cmp++;
        if (rd[31:0] !== 32'h1234) begin
            n_bad++; $display("FAIL single_bypass: got %h want 00001234", rd[31:0]);
        end
        edge_then_idle();
        n_cmp++;
        if (rd[31:0] !== 32'h1234) begin
            n_bad++; $display("FAIL single_stored: got %h want 00001234", rd[31:0]);
        end
        n_cmp++;
        if (trc_valid !== 2'b01) begin
            n_bad++; $display("FAIL single_trc_valid: got %b want 01", trc_valid);
        end
        n_cmp++;
        if ({trc_pc0, trc_addr0, trc_data0} !== {32'h3000, 5'd5, 32'h1234}) begin
            n_bad++;
            $display("FAIL single_trc0: got pc=%h addr=%0d data=%h want 3000/5/1234",
                     trc_pc0, trc_addr0, trc_data0);
        end
        edge_then_idle();
        n_cmp++;
        if (trc_valid !== 2'b00) begin
            n_bad++; $display("FAIL single_trc_pulse: got %b want 00", trc_valid);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA; wpc0 = 32'h100;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBBBB; wpc1 = 32'h104;
        ra = {5'd7, 5'd7};
        #1;
        n_cmp++;
        if (rd !== {32'hBBBB, 32'hBBBB}) begin
            n_bad++; $display("FAIL collide_bypass: got %h want BBBB on both", rd);
        end
        edge_then_idle();
        n_cmp++;
        if (rd !== {32'hBBBB, 32'hBBBB}) begin
            n_bad++; $display("FAIL collide_stored: got %h want BBBB on both", rd);
        end
        n_cmp++;
        if (trc_valid !== 2'b10) begin
            n_bad++; $display("FAIL collide_trc_valid: got %b want 10", trc_valid);
        end
        n_cmp++;
        if ({trc_pc1, trc_addr1, trc_data1} !== {32'h104, 5'd7, 32'hBBBB}) begin
            n_bad++;
            $display("FAIL collide_trc1: got pc=%h addr=%0d data=%h want 104/7/BBBB",
                     trc_pc1, trc_addr1, trc_data1);
        end
        // Port 0 trace must still hold the earlier write to register 5.
        n_cmp++;
        if ({trc_pc0, trc_addr0, trc_data0} !== {32'h3000, 5'd5, 32'h1234}) begin
            n_bad++;
            $display("FAIL collide_trc0_hold: got pc=%h addr=%0d data=%h want 3000/5/1234",
                     trc_pc0, trc_addr0, trc_data0);
        end
    endtask

    task automatic test_dual_distinct();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA0A0; wpc0 = 32'h200;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hB1B1; wpc1 = 32'h204;
        ra = {5'd11, 5'd10};
        #1;
        n_cmp++;
        if (rd !== {32'hB1B1, 32'hA0A0}) begin
            n_bad++; $display("FAIL dual_bypass: got %h want 0000b1b1_0000a0a0", rd);
        end
        edge_then_idle();
        n_cmp++;
        if (rd !== {32'hB1B1, 32'hA0A0}) begin
            n_bad++; $display("FAIL dual_stored: got %h want 0000b1b1_0000a0a0", rd);
        end
        n_cmp++;
        if (trc_valid !== 2'b11) begin
            n_bad++; $display("FAIL dual_trc_valid: got %b want 11", trc_valid);
        end
        n_cmp++;
        if ({trc_addr0, trc_data0, trc_addr1, trc_data1} !==
            {5'd10, 32'hA0A0, 5'd11, 32'hB1B1}) begin
            n_bad++;
            $display("FAIL dual_trc: got a0=%0d d0=%h a1=%0d d1=%h want 10/A0A0/11/B1B1",
                     trc_addr0, trc_data0, trc_addr1, trc_data1);
        end
    endtask

    task automatic test_write_zero();
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; wpc1 = 32'h300;
        ra = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rd !== 64'h0) begin
            n_bad++; $display("FAIL zero_bypass: got %h want 0", rd);
        end
        edge_then_idle();
        n_cmp++;
        if (rd !== 64'h0) begin
            n_bad++; $display("FAIL zero_stored: got %h want 0", rd);
        end
        n_cmp++;
        if (trc_valid !== 2'b00) begin
            n_bad++; $display("FAIL zero_trc_valid: got %b want 00", trc_valid);
        end
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL zero_busy0: got %b want 0", busy[0]);
        end
        n_cmp++;
        if (trc_data1 !== 32'hB1B1) begin
            n_bad++; $display("FAIL zero_trc1_hold: got %h want 0000b1b1", trc_data1);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        set_en = 1'b1; set_addr = 5'd9;
        edge_then_idle();
        n_cmp++;
        if (busy !== 32'h0000_0200) begin
            n_bad++; $display("FAIL sb_set: got %h want 00000200", busy);
        end
        @(negedge clk);
        set_en = 1'b1; set_addr = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        edge_then_idle();
        n_cmp++;
        if (busy !== 32'h0000_0200) begin
            n_bad++; $display("FAIL sb_set_beats_clear: got %h want 00000200", busy);
        end
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h77;
        set_en = 1'b1; set_addr = 5'd12;
        edge_then_idle();
        n_cmp++;
        if (busy !== 32'h0000_1000) begin
            n_bad++; $display("FAIL sb_clear: got %h want 00001000", busy);
        end
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h12;
        edge_then_idle();
        @(negedge clk);
        set_en = 1'b1; set_addr = 5'd0;
        edge_then_idle();
        n_cmp++;
        if (busy !== 32'h0) begin
            n_bad++; $display("FAIL sb_set_zero: got %h want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        RESET = 1'b1;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5555; wpc0 = 32'h400;
        set_en = 1'b1; set_addr = 5'd4;
        edge_then_idle();
        ra = {5'd5, 5'd3};
        #1;
        n_cmp++;
        if (rd !== 64'h0) begin
            n_bad++; $display("FAIL rstmid_rd: got %h want 0", rd);
        end
        n_cmp++;
        if (trc_valid !== 2'b00) begin
            n_bad++; $display("FAIL rstmid_trc_valid: got %b want 00", trc_valid);
        end
        n_cmp++;
        if (busy !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_busy: got %h want 0", busy);
        end
        n_cmp++;
        if ({trc_pc0, trc_data0, trc_data1} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_trc_fields: got pc0=%h d0=%h d1=%h want 0",
                     trc_pc0, trc_data0, trc_data1);
        end
    endtask

    initial begin
        idle();
        ra = '0;
        test_reset();
        test_single_write();
        test_collision();
        test_dual_distinct();
        test_write_zero();
        test_scoreboard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
